// File: rtl/mandelbrot_engine.sv
// mandelbrot_engine: iterative Mandelbrot/Julia escape-time engine; optional periodicity check via MANDELBROT_ENGINE_PERIODICITY_EN
module mandelbrot_engine #(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int TAG_WIDTH       = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0]  px_i,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0]  py_i,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0]  jx_i,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0]  jy_i,
  input  logic                                            julia_i,
  input  logic        [MAX_ITER_WIDTH-1:0]                max_iter_i,
  input  logic        [INTEGER_BITS+FRACTIONAL_BITS-1:0]  radius2_i,
  input  logic        [TAG_WIDTH-1:0]                     tag_i,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic        [MAX_ITER_WIDTH-1:0]                iter_o,
  output logic                                            escaped_o,
  output logic        [TAG_WIDTH-1:0]                     tag_o,
  input  logic                                            abort_i
);
  localparam int DW = INTEGER_BITS + FRACTIONAL_BITS;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic signed [2*DW-1:0] MAXV = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] MINV = ~MAXV;

  function automatic logic signed [DW-1:0] sat_mul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = (a * b) >>> FRACTIONAL_BITS;
    return (p > MAXV) ? MAXV[DW-1:0] : (p < MINV) ? MINV[DW-1:0] : p[DW-1:0];
  endfunction

  logic [1:0]                state_q, state_d;
  logic signed [DW-1:0]      x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic [DW-1:0]             r2_q, r2_d;
  logic [MAX_ITER_WIDTH-1:0] max_q, max_d, n_q, n_d, iter_q, iter_d;
  logic                      esc_q, esc_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic signed [DW-1:0]      x2, y2, xy, nx, ny;
  logic [DW:0]               mag;
  logic                      esc_hit, per_hit, lim_hit;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
  logic signed [DW-1:0]      snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic                      snap_v_q, snap_v_d, pow2;
`endif

  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign iter_o      = iter_q;
  assign escaped_o   = esc_q;
  assign tag_o       = tag_q;

  // one iteration's datapath: saturated squares, escape magnitude, next z
  always_comb begin
    x2      = sat_mul(x_q, x_q);
    y2      = sat_mul(y_q, y_q);
    xy      = sat_mul(x_q, y_q);
    mag     = {x2[DW-1], x2} + {y2[DW-1], y2};
    esc_hit = mag > {1'b0, r2_q};
    lim_hit = n_q == max_q;
    nx      = x2 - y2 + cx_q;
    ny      = (xy << 1) + cy_q;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
    per_hit = snap_v_q && x_q == snap_x_q && y_q == snap_y_q;
    pow2    = n_q != '0 && (n_q & (n_q - 1'b1)) == '0;
`else
    per_hit = 1'b0;
`endif
  end

  // job FSM: accept, iterate until a terminating rule fires, hold result until taken
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r2_d    = r2_q;
    max_d   = max_q;
    n_d     = n_q;
    iter_d  = iter_q;
    esc_d   = esc_q;
    tag_d   = tag_q;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    snap_v_d = snap_v_q;
`endif
    if (state_q == IDLE) begin
      if (in_valid_i) begin
        state_d = ITER;
        x_d     = px_i;
        y_d     = py_i;
        cx_d    = julia_i ? jx_i : px_i;
        cy_d    = julia_i ? jy_i : py_i;
        r2_d    = radius2_i;
        max_d   = max_iter_i;
        tag_d   = tag_i;
        n_d     = '0;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
        snap_v_d = 1'b0;
`endif
      end
    end else if (abort_i) begin
      state_d = IDLE;
    end else if (state_q == ITER) begin
      if (esc_hit || per_hit || lim_hit) begin
        state_d = DONE;
        iter_d  = (!esc_hit && per_hit) ? max_q : n_q;
        esc_d   = esc_hit;
      end else begin
        x_d = nx;
        y_d = ny;
        n_d = n_q + 1'b1;
      end
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
      if (pow2) begin
        snap_x_d = x_q;
        snap_y_d = y_q;
        snap_v_d = 1'b1;
      end
`endif
    end else if (out_ready_i) begin
      state_d = IDLE;
    end
  end

  // control and result registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      iter_q  <= '0;
      esc_q   <= 1'b0;
      tag_q   <= '0;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
      snap_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      esc_q   <= esc_d;
      tag_q   <= tag_d;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
      snap_v_q <= snap_v_d;
`endif
    end
  end

  // datapath registers, only meaningful while a job is live
  always_ff @(posedge clk_i) begin
    x_q   <= x_d;
    y_q   <= y_d;
    cx_q  <= cx_d;
    cy_q  <= cy_d;
    r2_q  <= r2_d;
    max_q <= max_d;
    n_q   <= n_d;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
    snap_x_q <= snap_x_d;
    snap_y_q <= snap_y_d;
`endif
  end
endmodule

// File: tb/tb_mandelbrot_engine.sv
// tb_mandelbrot_engine: table-driven directed bench for mandelbrot_engine
module tb_mandelbrot_engine;
  localparam int DW = 32;
  localparam int MW = 16;
  localparam int TW = 16;
`ifdef MANDELBROT_ENGINE_PERIODICITY_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif
  localparam logic [DW-1:0] ONE   = 32'h0100_0000;
  localparam logic [DW-1:0] TWO   = 32'h0200_0000;
  localparam logic [DW-1:0] THREE = 32'h0300_0000;
  localparam logic [DW-1:0] FOUR  = 32'h0400_0000;
  localparam logic [DW-1:0] HALF  = 32'h0080_0000;
  localparam logic [DW-1:0] NEG1  = 32'hFF00_0000;

  logic clk_i = 1'b0;
  logic rst_i, in_valid_i, in_ready_o, julia_i, out_valid_o, out_ready_i, escaped_o, abort_i;
  logic signed [DW-1:0] px_i, py_i, jx_i, jy_i;
  logic [DW-1:0] radius2_i;
  logic [MW-1:0] max_iter_i, iter_o;
  logic [TW-1:0] tag_i, tag_o;
  int n_chk = 0;
  int n_fail = 0;

  mandelbrot_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .px_i(px_i), .py_i(py_i), .jx_i(jx_i), .jy_i(jy_i), .julia_i(julia_i),
    .max_iter_i(max_iter_i), .radius2_i(radius2_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .iter_o(iter_o),
    .escaped_o(escaped_o), .tag_o(tag_o), .abort_i(abort_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          julia;
    logic [DW-1:0] px, py, jx, jy;
    logic [MW-1:0] mi;
    logic [DW-1:0] r2;
    logic [TW-1:0] tag;
    logic [MW-1:0] e_iter;
    logic          e_esc;
    int            e_lat;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start(input vec_t t, input logic ab);
    @(negedge clk_i);
    julia_i = t.julia; px_i = t.px; py_i = t.py; jx_i = t.jx; jy_i = t.jy;
    max_iter_i = t.mi; radius2_i = t.r2; tag_i = t.tag;
    in_valid_i = 1'b1; abort_i = ab;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 3000) begin
      @(posedge clk_i);
      #1 lat++;
    end
  endtask

  task automatic take();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    rst_i = 1'b1; in_valid_i = 1'b0; julia_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b0;
    px_i = '0; py_i = '0; jx_i = '0; jy_i = '0; max_iter_i = '0; radius2_i = '0; tag_i = '0;
    v[0] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd100, FOUR, 16'h0001, 16'd100, 1'b0, PER ? 4 : 102};
    v[1] = '{1'b0, THREE, 32'h0, 32'h0, 32'h0, 16'd100, FOUR, 16'h0002, 16'd0, 1'b1, 2};
    v[2] = '{1'b0, TWO, 32'h0, 32'h0, 32'h0, 16'd100, FOUR, 16'h0003, 16'd1, 1'b1, 3};
    v[3] = '{1'b1, HALF, 32'h0, 32'h0, 32'h0, 16'd20, FOUR, 16'hBEEF, 16'd20, 1'b0, PER ? 11 : 22};
    v[4] = '{1'b0, NEG1, 32'h0, 32'h0, 32'h0, 16'd1000, FOUR, 16'h0005, 16'd1000, 1'b0, PER ? 6 : 1002};
    v[5] = '{1'b0, ONE, 32'h0, 32'h0, 32'h0, 16'd0, FOUR, 16'h0006, 16'd0, 1'b0, 2};
    v[6] = '{1'b0, THREE, 32'h0, 32'h0, 32'h0, 16'd0, FOUR, 16'h0007, 16'd0, 1'b1, 2};
    v[7] = '{1'b0, 32'h0, ONE, 32'h0, 32'h0, 16'd10, FOUR, 16'h0008, 16'd10, 1'b0, PER ? 6 : 12};
    v[8] = '{1'b0, ONE, ONE, 32'h0, 32'h0, 16'd50, TWO, 16'h0009, 16'd1, 1'b1, 3};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_iter", iter_o, 0);
    chk("rst_escaped", escaped_o, 0);
    chk("rst_tag", tag_o, 0);
    @(negedge clk_i) rst_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      start(v[i], 1'b0);
      wait_done(lat);
      chk($sformatf("v%0d_iter", i), iter_o, v[i].e_iter);
      chk($sformatf("v%0d_esc", i), escaped_o, v[i].e_esc);
      chk($sformatf("v%0d_tag", i), tag_o, v[i].tag);
      chk($sformatf("v%0d_lat", i), lat, v[i].e_lat);
      take();
      chk($sformatf("v%0d_idle", i), in_ready_o, 1);
    end
    start(v[3], 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      chk("stall_valid", out_valid_o, 1);
      chk("stall_ready", in_ready_o, 0);
      chk("stall_iter", iter_o, 20);
      chk("stall_tag", tag_o, 16'hBEEF);
    end
    take();
    start(v[0], 1'b0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("midrst_ready", in_ready_o, 1);
    chk("midrst_tag", tag_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1 chk("midrst_no_valid", out_valid_o, 0);
    end
    start(v[0], 1'b0);
    @(negedge clk_i) abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    chk("abort_iter_ready", in_ready_o, 1);
    chk("abort_iter_valid", out_valid_o, 0);
    start(v[2], 1'b1);
    chk("abort_idle_accepted", in_ready_o, 0);
    wait_done(lat);
    chk("abort_idle_iter", iter_o, 1);
    chk("abort_idle_esc", escaped_o, 1);
    @(negedge clk_i) abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    chk("abort_done_valid", out_valid_o, 0);
    chk("abort_done_ready", in_ready_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
